biquad_iir_seq: RTL and testbench

- Parametrised second-order IIR section in Direct Form II with an internal sequencer.
- Replaces the externally driven enable/mux-select filter datapaths. Each filter instance now owns its own FSM, coefficient latch, single shared multiply-accumulate unit with saturation, and a start/done handshake.
- Sits between the ADC sample strobe and the DAC/output stage. One instance per filter type (low-pass, high-pass, band-pass) differs only in the coefficients applied.

---
 rtl/biquad_iir_seq.sv | 169 ++++++++++++++++
 tb/tb_biquad_iir_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/biquad_iir_seq.sv
// biquad_iir_seq: second-order Direct Form II IIR section.
// A six-state sequencer drives one shared multiplier through a five-step
// multiply-accumulate schedule. Every step result saturates to N bits.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; clear_state zeroes the delay line
// F1    | acc  = sat(u - a1*fk1)
// F2    | fnew = sat(acc - a2*fk2)
// Y0    | acc  = sat(b0*fnew)
// Y1    | acc  = sat(acc + b1*fk1)
// Y2    | yk = sat(acc + b2*fk2), shift delay line, pulse done
module biquad_iir_seq #(
  parameter int N    = 16,
  parameter int FRAC = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                clear_state,
  input  logic signed [N-1:0] uk,
  input  logic signed [N-1:0] b0,
  input  logic signed [N-1:0] b1,
  input  logic signed [N-1:0] b2,
  input  logic signed [N-1:0] a1,
  input  logic signed [N-1:0] a2,
  output logic signed [N-1:0] yk,
  output logic                done,
  output logic                busy,
  output logic                sat_flag
);

  typedef enum logic [2:0] {IDLE, F1, F2, Y0, Y1, Y2} state_t;

  // A shifted product outside the (N+1)-bit range forces the final N-bit
  // result to clamp in the same direction, so pre-clamping the product here
  // lets the sum stay N+2 bits wide without changing any result.
  localparam logic signed [2*N-1:0] TERM_MAX = {{N{1'b0}}, {N{1'b1}}};
  localparam logic signed [2*N-1:0] TERM_MIN = {{N{1'b1}}, {N{1'b0}}};
  localparam logic signed [N+1:0]   SUM_MAX  = {3'b000, {(N-1){1'b1}}};
  localparam logic signed [N+1:0]   SUM_MIN  = {3'b111, {(N-1){1'b0}}};

  state_t state;

  logic signed [N-1:0] u_lat, b0_lat, b1_lat, b2_lat, a1_lat, a2_lat;
  logic signed [N-1:0] fk1, fk2, fnew, acc;

  logic signed [N-1:0]   op_c, op_x, base;
  logic                  sub;
  logic signed [2*N-1:0] prod, shifted;
  logic signed [N:0]     term;
  logic signed [N+1:0]   sum;
  logic signed [N-1:0]   res;
  logic                  clamp;

  // Operand selection for the single multiplier and the accumulate base.
  always_comb begin
    op_c = '0;
    op_x = '0;
    base = '0;
    sub  = 1'b0;
    case (state)
      F1: begin op_c = a1_lat; op_x = fk1;  base = u_lat; sub = 1'b1; end
      F2: begin op_c = a2_lat; op_x = fk2;  base = acc;   sub = 1'b1; end
      Y0: begin op_c = b0_lat; op_x = fnew; base = '0;    end
      Y1: begin op_c = b1_lat; op_x = fk1;  base = acc;   end
      Y2: begin op_c = b2_lat; op_x = fk2;  base = acc;   end
      default: ;
    endcase
  end

  // Shared multiply, floor shift, pre-clamp, accumulate and saturate.
  always_comb begin
    prod    = op_c * op_x;
    shifted = prod >>> FRAC;
    if (shifted > TERM_MAX)
      term = {1'b0, {N{1'b1}}};
    else if (shifted < TERM_MIN)
      term = {1'b1, {N{1'b0}}};
    else
      term = shifted[N:0];
    if (sub)
      sum = {{2{base[N-1]}}, base} - {term[N], term};
    else
      sum = {{2{base[N-1]}}, base} + {term[N], term};
    clamp = 1'b0;
    if (sum > SUM_MAX) begin
      res   = {1'b0, {(N-1){1'b1}}};
      clamp = 1'b1;
    end else if (sum < SUM_MIN) begin
      res   = {1'b1, {(N-1){1'b0}}};
      clamp = 1'b1;
    end else begin
      res = sum[N-1:0];
    end
  end

  // Sequencer, datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      u_lat    <= '0;
      b0_lat   <= '0;
      b1_lat   <= '0;
      b2_lat   <= '0;
      a1_lat   <= '0;
      a2_lat   <= '0;
      fk1      <= '0;
      fk2      <= '0;
      fnew     <= '0;
      acc      <= '0;
      yk       <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            u_lat    <= uk;
            b0_lat   <= b0;
            b1_lat   <= b1;
            b2_lat   <= b2;
            a1_lat   <= a1;
            a2_lat   <= a2;
            sat_flag <= 1'b0;
            busy     <= 1'b1;
            state    <= F1;
          end else if (clear_state) begin
            fk1 <= '0;
            fk2 <= '0;
          end
        end
        F1: begin
          acc <= res;
          if (clamp) sat_flag <= 1'b1;
          state <= F2;
        end
        F2: begin
          fnew <= res;
          if (clamp) sat_flag <= 1'b1;
          state <= Y0;
        end
        Y0: begin
          acc <= res;
          if (clamp) sat_flag <= 1'b1;
          state <= Y1;
        end
        Y1: begin
          acc <= res;
          if (clamp) sat_flag <= 1'b1;
          state <= Y2;
        end
        Y2: begin
          yk   <= res;
          fk2  <= fk1;
          fk1  <= fnew;
          done <= 1'b1;
          busy <= 1'b0;
          if (clamp) sat_flag <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_biquad_iir_seq.sv
// tb_biquad_iir_seq: directed tests with hand-computed expected outputs.
module tb_biquad_iir_seq;

  localparam int N = 16;

  logic clk = 1'b0;
  logic reset, start, clear_state;
  logic signed [N-1:0] uk, b0, b1, b2, a1, a2;
  logic signed [N-1:0] yk;
  logic done, busy, sat_flag;

  int errors = 0;
  int checks = 0;

  biquad_iir_seq #(.N(N), .FRAC(8)) dut (
    .clk(clk), .reset(reset), .start(start), .clear_state(clear_state),
    .uk(uk), .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2),
    .yk(yk), .done(done), .busy(busy), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic set_coef(input int c0, input int c1, input int c2,
                          input int ca1, input int ca2);
    b0 = N'(c0); b1 = N'(c1); b2 = N'(c2); a1 = N'(ca1); a2 = N'(ca2);
  endtask

  // Start one sample and wait (bounded) for done; returns latency in edges.
  task automatic run_sample(input int u, output logic signed [N-1:0] y,
                            output int lat);
    @(negedge clk);
    uk    = N'(u);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    y = yk;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (yk !== 16'sd0 || done !== 1'b0 || busy !== 1'b0 || sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: yk=%0d done=%b busy=%b sat=%b, want 0 0 0 0",
               yk, done, busy, sat_flag);
    end
  endtask

  task automatic test_pass_through();
    logic signed [N-1:0] y;
    int lat;
    do_reset();
    set_coef(256, 0, 0, 0, 0);
    run_sample(100, y, lat);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL pass_latency: got %0d want 5", lat);
    end
    checks++;
    if (y !== 16'sd100 || sat_flag !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pass_value: yk=%0d sat=%b busy=%b, want 100 0 0", y, sat_flag, busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || yk !== 16'sd100) begin
      errors++;
      $display("FAIL pass_done_pulse: done=%b yk=%0d, want 0 100", done, yk);
    end
  endtask

  task automatic test_unit_delay();
    logic signed [N-1:0] y;
    int lat;
    int u_vec [3] = '{100, 200, -50};
    int y_exp [3] = '{0, 100, 200};
    do_reset();
    set_coef(0, 256, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      run_sample(u_vec[i], y, lat);
      checks++;
      if (lat !== 5 || y !== N'(y_exp[i])) begin
        errors++;
        $display("FAIL unit_delay[%0d]: yk=%0d lat=%0d, want %0d lat 5", i, y, lat, y_exp[i]);
      end
    end
  endtask

  task automatic test_feedback();
    logic signed [N-1:0] y;
    int lat;
    int u_vec [3] = '{256, 0, 0};
    int y_exp [3] = '{256, 128, 64};
    do_reset();
    set_coef(256, 0, 0, -128, 0);
    for (int i = 0; i < 3; i++) begin
      run_sample(u_vec[i], y, lat);
      checks++;
      if (lat !== 5 || y !== N'(y_exp[i])) begin
        errors++;
        $display("FAIL feedback[%0d]: yk=%0d lat=%0d, want %0d lat 5", i, y, lat, y_exp[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [N-1:0] y;
    int lat;
    do_reset();
    set_coef(32767, 0, 0, 0, 0);
    run_sample(32767, y, lat);
    checks++;
    if (y !== 16'sd32767 || sat_flag !== 1'b1) begin
      errors++;
      $display("FAIL sat_high: yk=%0d sat=%b, want 32767 1", y, sat_flag);
    end
    set_coef(32767, 0, 0, 0, 0);
    run_sample(-32768, y, lat);
    checks++;
    if (y !== -16'sd32768 || sat_flag !== 1'b1) begin
      errors++;
      $display("FAIL sat_low: yk=%0d sat=%b, want -32768 1", y, sat_flag);
    end
    set_coef(256, 0, 0, 0, 0);
    run_sample(10, y, lat);
    checks++;
    if (y !== 16'sd10 || sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL sat_clear: yk=%0d sat=%b, want 10 0", y, sat_flag);
    end
  endtask

  task automatic test_back_to_back();
    int dones;
    do_reset();
    set_coef(256, 0, 0, 0, 0);
    @(negedge clk);
    uk = 16'sd40;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    uk = 16'sd999;
    b0 = 16'sd512;
    dones = 0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 2) start = 1'b1;
      @(posedge clk);
      #1;
      if (i == 2) start = 1'b0;
      if (done) dones++;
    end
    checks++;
    if (dones !== 1 || yk !== 16'sd40) begin
      errors++;
      $display("FAIL busy_start_ignored: dones=%0d yk=%0d, want 1 40", dones, yk);
    end
  endtask

  task automatic test_clear_state();
    logic signed [N-1:0] y;
    int lat;
    do_reset();
    set_coef(0, 256, 0, 0, 0);
    run_sample(100, y, lat);
    @(negedge clk);
    clear_state = 1'b1;
    @(negedge clk);
    clear_state = 1'b0;
    run_sample(5, y, lat);
    checks++;
    if (y !== 16'sd0) begin
      errors++;
      $display("FAIL clear_state: yk=%0d, want 0", y);
    end
    run_sample(7, y, lat);
    checks++;
    if (y !== 16'sd5) begin
      errors++;
      $display("FAIL clear_state_next: yk=%0d, want 5", y);
    end
  endtask

  task automatic test_reset_mid();
    logic signed [N-1:0] y;
    int lat;
    int dones;
    do_reset();
    set_coef(256, 0, 0, 0, 0);
    run_sample(100, y, lat);
    @(negedge clk);
    uk = 16'sd77;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || yk !== 16'sd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b yk=%0d done=%b, want 0 0 0", busy, yk, done);
    end
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: dones=%0d, want 0", dones);
    end
    set_coef(256, 0, 0, 0, 0);
    run_sample(100, y, lat);
    checks++;
    if (lat !== 5 || y !== 16'sd100 || sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_restart: yk=%0d lat=%0d sat=%b, want 100 5 0", y, lat, sat_flag);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    clear_state = 1'b0;
    uk = '0;
    set_coef(0, 0, 0, 0, 0);
    test_reset();
    test_pass_through();
    test_unit_delay();
    test_feedback();
    test_saturation();
    test_back_to_back();
    test_clear_state();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
